regfile_access_scheduler: RTL and testbench
===========================================

Name: regfile_access_scheduler

Overview:
Request front-end that sits directly upstream of the multi-port register file. Each of READ_WRITE_PORTS clients issues read/write requests with a binary register index over a valid/ready handshake. The block resolves same-cycle write/write and read/write hazards using round-robin priority, then drives the register file's one-hot select, write strobe and data buses from registers. It captures the file's read data and returns a per-port response with a fixed latency.

Parameters:
DATA_WIDTH, 32, width of one register / data lane
NUM_REGISTERS, 3, registers in the downstream file
READ_WRITE_PORTS, 2, number of client ports (P)
ADDR_WIDTH (localparam), max(1,$clog2(NUM_REGISTERS)), binary index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  P  per-port request valid
req_ready_o  out  P  per-port accept (combinational)
req_write_i  in  P  1=write, 0=read
req_addr_i  in  P*ADDR_WIDTH  binary register index, lane j at [j*ADDR_WIDTH+:ADDR_WIDTH]
req_data_i  in  P*DATA_WIDTH  write data per lane
rsp_valid_o  out  P  one-cycle response pulse
rsp_data_o  out  P*DATA_WIDTH  read data (write: echo of written data)
rsp_err_o  out  P  index >= NUM_REGISTERS
register_select_o  out  NUM_REGISTERS*P  one-hot select per port, lane j at [j*NUM_REGISTERS+:NUM_REGISTERS]
data_o  out  DATA_WIDTH*P  write data to file
write_select_o  out  P  write strobe per port
rf_data_i  in  DATA_WIDTH*P  per-port read data from file, valid in the issue cycle

Behaviour:
- Reset (async, any time): all outputs 0, RR pointer 0, in-flight requests dropped with no response.
- Accept: cycle T, port j fires when req_valid_i[j] && req_ready_o[j].
- Issue stage (registered): in cycle T+1, register_select_o lane j = one-hot(addr) and write_select_o[j] = req_write_i[j]; data_o lane j = req_data_i lane j. Lanes with no accepted request drive select 0, strobe 0 and data 0.
- Response: in cycle T+2, rsp_valid_o[j] = 1.
  - Read: rsp_data_o = rf_data_i lane j sampled in T+1.
  - Write: rsp_data_o = the written data.
- Throughput: one request per port per cycle; back-to-back accepts pipeline fully. Responses have no backpressure.
- Hazard resolution (combinational on current valids; ports with valid=0 are ignored):
  - Write/write, same index: only one write is granted. Winner is the first port at or after rr_ptr (cyclic); the others see ready=0.
  - Read/write, same index: the read sees ready=0. The read is then accepted on a later cycle and observes the new value.
  - Read/read and different indices: all ready=1.
- RR pointer: advances to winner+1 mod P only on a cycle where a write/write conflict was resolved; otherwise it holds.
- Hazards against in-flight issue-stage writes: a read accepted at T+1 of a write to the same index is issued at T+2, after the file has written at the end of T+1, so it returns the new value. No stall is needed.
- Out-of-range index (>= NUM_REGISTERS):
  - The request is accepted with ready=1; it never conflicts and never blocks other ports.
  - Issue stage drives select 0 and strobe 0, so the file is untouched.
  - Response in T+2 with rsp_err_o=1 and rsp_data_o=0.
- rsp_err_o is 0 whenever rsp_valid_o is 0.
- NUM_REGISTERS=1 or P=1: hazard logic degenerates; ADDR_WIDTH is forced to 1.

Decomposition:
- Package regfile_pkg: ADDR_WIDTH derivation function, binary-to-one-hot function, lane slicing helper constants.
- Sub-module rr_conflict_arbiter: P request vectors of {valid, write, addr} plus rr_ptr in, P grant bits and next-pointer enable out. This is purely combinational; rr_ptr stays in the parent.

Test Plan:
- Reset then idle: all outputs 0; assert reset_n_i mid-burst -> rsp_valid_o stays 0 and select/strobe go 0 immediately.
- Port0 writes idx2 data 0xDEADBEEF at T -> T+1 register_select_o lane0=3'b100, write_select_o=2'b01, data_o lane0=0xDEADBEEF; T+2 rsp_valid_o=2'b01. Port1 then reads idx2 -> rsp_data_o lane1=0xDEADBEEF.
- Both ports write idx1 (0x11, 0x22), rr_ptr=0 -> ready=2'b01, port0 wins, pointer becomes 1. Port1 held with valid -> accepted next cycle; the final read returns 0x22. Repeating the same conflict with ptr=1 -> port1 wins.
- Port0 writes idx0 0xA5 while port1 reads idx0 in the same cycle -> port1 ready=0. Port1 is accepted next cycle -> rsp_data_o lane1=0xA5.
- Port1 reads idx3 -> accepted, no select or strobe asserted, T+2 rsp_err_o=2'b10 and rsp_data_o lane1=0. Register contents are unchanged (verify with read-back).
- Streaming: both ports issue 8 back-to-back reads of distinct indices -> 8 consecutive rsp_valid_o pulses per port, starting 2 cycles after the first accept, with no bubbles.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and index helpers for the register file scheduler
package regfile_pkg;

    localparam int ONEHOT_MAX = 256;

    // Index width never collapses to zero, even for a single register or port.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [ONEHOT_MAX-1:0] to_onehot(input logic [31:0] idx);
        logic [ONEHOT_MAX-1:0] oh;
        oh = '0;
        oh[idx[7:0]] = 1'b1;
        return oh;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/regfile_access_scheduler_if.sv
// rtl/regfile_access_scheduler_if.sv - client request/response and register file bus bundle
interface regfile_access_scheduler_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_REGISTERS    = 3,
    parameter int READ_WRITE_PORTS = 2
) ();
    localparam int P  = READ_WRITE_PORTS;
    localparam int AW = addr_width(NUM_REGISTERS);

    logic [P-1:0]               req_valid_i;
    logic [P-1:0]               req_ready_o;
    logic [P-1:0]               req_write_i;
    logic [P*AW-1:0]            req_addr_i;
    logic [P*DATA_WIDTH-1:0]    req_data_i;
    logic [P-1:0]               rsp_valid_o;
    logic [P*DATA_WIDTH-1:0]    rsp_data_o;
    logic [P-1:0]               rsp_err_o;
    logic [NUM_REGISTERS*P-1:0] register_select_o;
    logic [DATA_WIDTH*P-1:0]    data_o;
    logic [P-1:0]               write_select_o;
    logic [DATA_WIDTH*P-1:0]    rf_data_i;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_data_i, rf_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               register_select_o, data_o, write_select_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_data_i, rf_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               register_select_o, data_o, write_select_o
    );

endinterface

// File: rtl/rr_conflict_arbiter.sv
// rtl/rr_conflict_arbiter.sv - combinational same-index hazard resolution with round-robin write priority
module rr_conflict_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS    = 3,
    parameter int READ_WRITE_PORTS = 2,
    localparam int AW = addr_width(NUM_REGISTERS),
    localparam int PW = addr_width(READ_WRITE_PORTS)
) (
    input  logic [READ_WRITE_PORTS-1:0]    valid_i,
    input  logic [READ_WRITE_PORTS-1:0]    write_i,
    input  logic [READ_WRITE_PORTS*AW-1:0] addr_i,
    input  logic [PW-1:0]                  rr_ptr_i,
    output logic [READ_WRITE_PORTS-1:0]    grant_o,
    output logic                           adv_en_o,
    output logic [PW-1:0]                  adv_ptr_o
);
    localparam int P = READ_WRITE_PORTS;
    localparam logic [AW:0] NR_L = (AW+1)'(NUM_REGISTERS);

    logic [AW-1:0] lane_addr [P];
    logic [P-1:0]  in_range;
    logic [P-1:0]  wr;
    logic [P-1:0]  conflict;

    // Cyclic distance from the pointer; smaller distance wins a write/write tie.
    function automatic int prio(input int port, input int ptr);
        return (port >= ptr) ? port - ptr : port + P - ptr;
    endfunction

    always_comb begin
        for (int j = 0; j < P; j++) begin
            lane_addr[j] = addr_i[j*AW +: AW];
        end
    end

    always_comb begin
        in_range = '0;
        wr       = '0;
        for (int j = 0; j < P; j++) begin
            in_range[j] = ({1'b0, lane_addr[j]} < NR_L);
            wr[j]       = valid_i[j] & write_i[j] & in_range[j];
        end
    end

    always_comb begin
        grant_o  = '1;
        conflict = '0;
        for (int j = 0; j < P; j++) begin
            for (int i = 0; i < P; i++) begin
                if (i != j && wr[i] && valid_i[j] && in_range[j] &&
                    lane_addr[i] == lane_addr[j]) begin
                    if (!write_i[j]) begin
                        grant_o[j] = 1'b0;
                    end else begin
                        conflict[j] = 1'b1;
                        if (prio(i, int'(rr_ptr_i)) < prio(j, int'(rr_ptr_i))) begin
                            grant_o[j] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // First conflicting write found scanning from the pointer is its group's winner.
    always_comb begin
        adv_en_o  = 1'b0;
        adv_ptr_o = '0;
        for (int k = 0; k < P; k++) begin
            if (!adv_en_o && conflict[(int'(rr_ptr_i) + k) % P]) begin
                adv_en_o  = 1'b1;
                adv_ptr_o = PW'((int'(rr_ptr_i) + k + 1) % P);
            end
        end
    end

endmodule

// File: rtl/regfile_access_scheduler.sv
// rtl/regfile_access_scheduler.sv - per-port request front-end driving a multi-port register file
module regfile_access_scheduler
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_REGISTERS    = 3,
    parameter int READ_WRITE_PORTS = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    regfile_access_scheduler_if.slave   bus
);
    localparam int P  = READ_WRITE_PORTS;
    localparam int DW = DATA_WIDTH;
    localparam int NR = NUM_REGISTERS;
    localparam int AW = addr_width(NR);
    localparam int PW = addr_width(P);
    localparam logic [AW:0] NR_L = (AW+1)'(NR);

    logic [P-1:0]      grant;
    logic [P-1:0]      fire;
    logic              adv_en;
    logic [PW-1:0]     adv_ptr;
    logic [PW-1:0]     rr_ptr;

    logic [NR*P-1:0]   sel_d, sel_q;
    logic [P-1:0]      wstb_d, wstb_q;
    logic [DW*P-1:0]   data_d, data_q;
    logic [P-1:0]      iss_vld_q, iss_err_d, iss_err_q, iss_wr_d, iss_wr_q;
    logic [P-1:0]      rsp_vld_q, rsp_err_q;
    logic [DW*P-1:0]   rsp_data_d, rsp_data_q;
    logic [AW-1:0]     lane_addr;
    logic [ONEHOT_MAX-1:0] oh;

    rr_conflict_arbiter #(
        .NUM_REGISTERS   (NR),
        .READ_WRITE_PORTS(P)
    ) u_arb (
        .valid_i  (bus.req_valid_i),
        .write_i  (bus.req_write_i),
        .addr_i   (bus.req_addr_i),
        .rr_ptr_i (rr_ptr),
        .grant_o  (grant),
        .adv_en_o (adv_en),
        .adv_ptr_o(adv_ptr)
    );

    assign bus.req_ready_o = grant & {P{reset_n_i}};
    assign fire            = bus.req_valid_i & bus.req_ready_o;

    // Out-of-range requests still occupy the pipeline but never touch the file.
    always_comb begin
        sel_d     = '0;
        wstb_d    = '0;
        data_d    = '0;
        iss_err_d = '0;
        iss_wr_d  = '0;
        lane_addr = '0;
        oh        = '0;
        for (int j = 0; j < P; j++) begin
            if (fire[j]) begin
                lane_addr = bus.req_addr_i[lane_lo(j, AW) +: AW];
                data_d[lane_lo(j, DW) +: DW] = bus.req_data_i[lane_lo(j, DW) +: DW];
                iss_wr_d[j] = bus.req_write_i[j];
                if ({1'b0, lane_addr} < NR_L) begin
                    oh = to_onehot(32'(lane_addr));
                    sel_d[lane_lo(j, NR) +: NR] = oh[NR-1:0];
                    wstb_d[j] = bus.req_write_i[j];
                end else begin
                    iss_err_d[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rsp_data_d = '0;
        for (int j = 0; j < P; j++) begin
            if (iss_vld_q[j] && !iss_err_q[j]) begin
                rsp_data_d[lane_lo(j, DW) +: DW] = iss_wr_q[j] ? data_q[lane_lo(j, DW) +: DW]
                                                               : bus.rf_data_i[lane_lo(j, DW) +: DW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr     <= '0;
            sel_q      <= '0;
            wstb_q     <= '0;
            data_q     <= '0;
            iss_vld_q  <= '0;
            iss_err_q  <= '0;
            iss_wr_q   <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            if (adv_en) begin
                rr_ptr <= adv_ptr;
            end
            sel_q      <= sel_d;
            wstb_q     <= wstb_d;
            data_q     <= data_d;
            iss_vld_q  <= fire;
            iss_err_q  <= iss_err_d;
            iss_wr_q   <= iss_wr_d;
            rsp_vld_q  <= iss_vld_q;
            rsp_err_q  <= iss_err_q;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.register_select_o = sel_q;
    assign bus.write_select_o    = wstb_q;
    assign bus.data_o            = data_q;
    assign bus.rsp_valid_o       = rsp_vld_q;
    assign bus.rsp_err_o         = rsp_err_q;
    assign bus.rsp_data_o        = rsp_data_q;

endmodule

// File: tb/tb_regfile_access_scheduler.sv
// tb/tb_regfile_access_scheduler.sv - randomized and directed bench with a behavioural scheduler model
module tb_regfile_access_scheduler;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int NR = 3;
    localparam int P  = 2;
    localparam int AW = addr_width(NR);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    regfile_access_scheduler_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .READ_WRITE_PORTS(P)) bus ();

    regfile_access_scheduler #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .READ_WRITE_PORTS(P)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int r);
        return 32'h1000_0000 + 32'(r);
    endfunction

    // Register file environment: reads follow the select lines, writes land on the clock edge.
    logic [DW-1:0] rf_mem [NR];
    logic          env_loaded = 1'b0;

    always_comb begin
        bus.rf_data_i = '0;
        for (int j = 0; j < P; j++) begin
            for (int r = 0; r < NR; r++) begin
                if (bus.register_select_o[j*NR + r]) bus.rf_data_i[j*DW +: DW] = rf_mem[r];
            end
        end
    end

    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int r = 0; r < NR; r++) rf_mem[r] <= init_val(r);
            env_loaded <= 1'b1;
        end else begin
            for (int j = 0; j < P; j++)
                for (int r = 0; r < NR; r++)
                    if (bus.write_select_o[j] && bus.register_select_o[j*NR + r])
                        rf_mem[r] <= bus.data_o[j*DW +: DW];
        end
    end

    typedef struct packed {
        logic [NR*P-1:0] sel;
        logic [P-1:0]    ws;
        logic [DW*P-1:0] dat;
        logic [P-1:0]    rv;
        logic [P-1:0]    re;
        logic [DW*P-1:0] rd;
    } stage_t;

    stage_t        st1, st2, nxt;
    logic [DW-1:0] ref_regs [NR];
    logic          model_init = 1'b0;
    int            mptr;
    int            ma [P];
    logic [P-1:0]  minr, misw, mrdy, mfire;
    int            wcnt [NR];
    int            wwin [NR];
    logic          moved;

    // Model: per-index write counts and cyclic first-writer decide ready; reads see committed state.
    always @(negedge clk) begin
        if (!model_init) begin
            for (int r = 0; r < NR; r++) ref_regs[r] = init_val(r);
            model_init = 1'b1;
        end
        if (!reset_n) begin
            chk("rst_ready", bus.req_ready_o, 0);
            chk("rst_sel", bus.register_select_o, 0);
            chk("rst_wstb", bus.write_select_o, 0);
            chk("rst_data", bus.data_o, 0);
            chk("rst_rsp_valid", bus.rsp_valid_o, 0);
            chk("rst_rsp_err", bus.rsp_err_o, 0);
            chk("rst_rsp_data", bus.rsp_data_o, 0);
            st1 = '0;
            st2 = '0;
            mptr = 0;
        end else begin
            for (int r = 0; r < NR; r++) begin wcnt[r] = 0; wwin[r] = -1; end
            for (int j = 0; j < P; j++) begin
                ma[j]   = int'(bus.req_addr_i[j*AW +: AW]);
                minr[j] = ma[j] < NR;
                misw[j] = bus.req_valid_i[j] && bus.req_write_i[j] && minr[j];
            end
            for (int k = 0; k < P; k++) begin
                int p;
                p = (mptr + k) % P;
                if (misw[p]) begin
                    wcnt[ma[p]]++;
                    if (wwin[ma[p]] < 0) wwin[ma[p]] = p;
                end
            end
            for (int j = 0; j < P; j++) begin
                if (!bus.req_valid_i[j] || !minr[j]) mrdy[j] = 1'b1;
                else if (bus.req_write_i[j])        mrdy[j] = (wwin[ma[j]] == j);
                else                                 mrdy[j] = (wcnt[ma[j]] == 0);
            end
            chk("ready", bus.req_ready_o, mrdy);
            chk("issue_sel", bus.register_select_o, st1.sel);
            chk("issue_wstb", bus.write_select_o, st1.ws);
            chk("issue_data", bus.data_o, st1.dat);
            chk("rsp_valid", bus.rsp_valid_o, st2.rv);
            chk("rsp_err", bus.rsp_err_o, st2.re);
            chk("rsp_data", bus.rsp_data_o, st2.rd);

            for (int j = 0; j < P; j++)
                for (int r = 0; r < NR; r++)
                    if (st1.ws[j] && st1.sel[j*NR + r]) ref_regs[r] = st1.dat[j*DW +: DW];
            st2 = st1;

            nxt   = '0;
            mfire = bus.req_valid_i & mrdy;
            for (int j = 0; j < P; j++) begin
                if (mfire[j]) begin
                    nxt.dat[j*DW +: DW] = bus.req_data_i[j*DW +: DW];
                    nxt.rv[j] = 1'b1;
                    if (minr[j]) begin
                        nxt.sel[j*NR + ma[j]] = 1'b1;
                        nxt.ws[j] = bus.req_write_i[j];
                        nxt.rd[j*DW +: DW] = bus.req_write_i[j] ? bus.req_data_i[j*DW +: DW]
                                                                 : ref_regs[ma[j]];
                    end else begin
                        nxt.re[j] = 1'b1;
                    end
                end
            end
            st1 = nxt;

            moved = 1'b0;
            for (int k = 0; k < P; k++) begin
                int p;
                p = (mptr + k) % P;
                if (!moved && misw[p] && wcnt[ma[p]] > 1) begin
                    mptr  = (p + 1) % P;
                    moved = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int j, input logic v, input logic w, input int a, input logic [DW-1:0] d);
        bus.req_valid_i[j] = v;
        bus.req_write_i[j] = w;
        bus.req_addr_i[j*AW +: AW] = AW'(a);
        bus.req_data_i[j*DW +: DW] = d;
    endtask

    task automatic idle_all();
        for (int j = 0; j < P; j++) drive(j, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic random_cycles(input int n);
        logic [P-1:0] pend;
        pend = '0;
        for (int c = 0; c < n; c++) begin
            tick();
            for (int j = 0; j < P; j++) begin
                if (!(pend[j] && $urandom_range(0, 3) != 0)) begin
                    if ($urandom_range(0, 2) == 0) drive(j, 1'b0, 1'b0, 0, '0);
                    else drive(j, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom);
                end
            end
            @(negedge clk);
            pend = bus.req_valid_i & ~bus.req_ready_o;
        end
    endtask

    logic [P-1:0] hist [12];

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_rsp_valid", bus.rsp_valid_o, 0);
        chk("idle_sel", bus.register_select_o, 0);

        // Write idx2 from port0, read it back on port1.
        tick(); drive(0, 1'b1, 1'b1, 2, 32'hDEADBEEF);
        @(negedge clk);
        tick(); idle_all();
        @(negedge clk);
        chk("wr_sel_lane0", bus.register_select_o[NR-1:0], 3'b100);
        chk("wr_wstb", bus.write_select_o, 2'b01);
        chk("wr_data_lane0", bus.data_o[DW-1:0], 32'hDEADBEEF);
        tick(); drive(1, 1'b1, 1'b0, 2, '0);
        @(negedge clk);
        chk("wr_rsp_valid", bus.rsp_valid_o, 2'b01);
        chk("wr_rsp_echo", bus.rsp_data_o[DW-1:0], 32'hDEADBEEF);
        tick(); idle_all();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rd_rsp_valid", bus.rsp_valid_o, 2'b10);
        chk("rd_rsp_lane1", bus.rsp_data_o[2*DW-1:DW], 32'hDEADBEEF);

        // Write/write on idx1 with pointer 0, then with pointer 1.
        tick(); drive(0, 1'b1, 1'b1, 1, 32'h11); drive(1, 1'b1, 1'b1, 1, 32'h22);
        @(negedge clk);
        chk("ww_ptr0_ready", bus.req_ready_o, 2'b01);
        tick(); drive(0, 1'b0, 1'b0, 0, '0);
        @(negedge clk);
        chk("ww_held_ready", bus.req_ready_o, 2'b11);
        tick(); idle_all(); drive(0, 1'b1, 1'b0, 1, '0);
        @(negedge clk);
        tick(); idle_all();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("ww_ptr0_final", bus.rsp_data_o[DW-1:0], 32'h22);
        tick(); drive(0, 1'b1, 1'b1, 1, 32'h33); drive(1, 1'b1, 1'b1, 1, 32'h44);
        @(negedge clk);
        chk("ww_ptr1_ready", bus.req_ready_o, 2'b10);
        tick(); drive(1, 1'b0, 1'b0, 0, '0);
        @(negedge clk);
        tick(); idle_all(); drive(1, 1'b1, 1'b0, 1, '0);
        @(negedge clk);
        tick(); idle_all();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("ww_ptr1_final", bus.rsp_data_o[2*DW-1:DW], 32'h33);

        // Read/write on idx0 in the same cycle.
        tick(); drive(0, 1'b1, 1'b1, 0, 32'hA5); drive(1, 1'b1, 1'b0, 0, '0);
        @(negedge clk);
        chk("rw_ready", bus.req_ready_o, 2'b01);
        tick(); drive(0, 1'b0, 1'b0, 0, '0);
        @(negedge clk);
        chk("rw_retry_ready", bus.req_ready_o, 2'b11);
        tick(); idle_all();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rw_read_new", bus.rsp_data_o[2*DW-1:DW], 32'hA5);

        // Out-of-range read on port1.
        tick(); drive(1, 1'b1, 1'b0, 3, '0);
        @(negedge clk);
        chk("oor_ready", bus.req_ready_o, 2'b11);
        tick(); idle_all();
        @(negedge clk);
        chk("oor_sel", bus.register_select_o, 0);
        chk("oor_wstb", bus.write_select_o, 0);
        tick();
        @(negedge clk);
        chk("oor_err", bus.rsp_err_o, 2'b10);
        chk("oor_data", bus.rsp_data_o[2*DW-1:DW], 0);
        tick(); drive(1, 1'b1, 1'b0, 0, '0);
        @(negedge clk);
        tick(); idle_all();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("oor_readback", bus.rsp_data_o[2*DW-1:DW], 32'hA5);

        // Streaming reads on both ports.
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 8) begin
                drive(0, 1'b1, 1'b0, i % 3, '0);
                drive(1, 1'b1, 1'b0, (i + 1) % 3, '0);
            end else begin
                idle_all();
            end
            @(negedge clk);
            hist[i] = bus.rsp_valid_o;
        end
        for (int i = 0; i < 12; i++)
            chk($sformatf("stream_rsp_%0d", i), hist[i], (i >= 2 && i < 10) ? 2'b11 : 2'b00);

        random_cycles(400);

        // Reset in the middle of traffic.
        tick(); drive(0, 1'b1, 1'b1, 2, 32'hCAFE0001); drive(1, 1'b1, 1'b0, 0, '0);
        @(negedge clk);
        tick(); reset_n = 1'b0; idle_all();
        #1;
        chk("midrst_sel", bus.register_select_o, 0);
        chk("midrst_wstb", bus.write_select_o, 0);
        chk("midrst_rsp", bus.rsp_valid_o, 0);
        repeat (2) @(negedge clk);
        chk("midrst_rsp_late", bus.rsp_valid_o, 0);
        tick(); reset_n = 1'b1;

        random_cycles(150);
        tick(); idle_all();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
